// File: rtl/axis_fifo.sv
// -----------------------------------------------------------------------------
// axis_fifo
//   Synchronous AXI4-Stream FIFO. Holds up to DEPTH beats in total: the beats in
//   a DEPTH-entry array plus the one in a registered output stage. All sideband
//   fields (tkeep, tlast, tid, tdest, tuser) pass through unchanged. tlast has no
//   effect on flow. No combinational path exists between the two handshakes:
//   s_axis_tready depends only on registered state, and m_axis_* are flops.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   s_axis_*             input stream (s_axis_tready is an output)
//   m_axis_*             output stream (m_axis_tready is an input)
//   status_depth         beats currently held, 0..DEPTH
//   status_full          status_depth == DEPTH
//   status_empty         status_depth == 0
// -----------------------------------------------------------------------------
module axis_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  output logic [AW:0]           status_depth,
  output logic                  status_full,
  output logic                  status_empty
);

  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          m_valid_q, m_valid_d;
  logic [EW-1:0] out_q, out_d;

  logic [EW-1:0] s_beat;
  logic [AW:0]   arr_count;
  logic          arr_empty;
  logic          push;
  logic          out_free;
  logic          load_arr;
  logic          bypass;
  logic          write_arr;

  assign s_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                   s_axis_tid, s_axis_tdest, s_axis_tuser};

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
          m_axis_tid, m_axis_tdest, m_axis_tuser} = out_q;
  assign m_axis_tvalid = m_valid_q;

  // Occupancy comes from registered pointers plus the output-stage valid only,
  // so s_axis_tready never sees m_axis_tready combinationally.
  assign arr_count     = wr_ptr_q - rd_ptr_q;
  assign arr_empty     = (wr_ptr_q == rd_ptr_q);
  assign status_depth  = arr_count + {{AW{1'b0}}, m_valid_q};
  assign status_full   = (status_depth == FULL_COUNT);
  assign status_empty  = (status_depth == '0);
  assign s_axis_tready = !status_full;

  assign push     = s_axis_tvalid && s_axis_tready;
  assign out_free = !m_valid_q || m_axis_tready;
  // Output stage takes the array head first; only when the array is empty does
  // an incoming beat skip the array, which gives the one-cycle first-word latency.
  assign load_arr  = out_free && !arr_empty;
  assign bypass    = push && out_free && arr_empty;
  assign write_arr = push && !bypass;

  // NOTE: every variable driven here gets a default first, otherwise a path that
  // leaves it unassigned infers a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, write_arr};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, load_arr};
    out_d     = out_q;
    m_valid_d = m_valid_q;
    if (load_arr) begin
      out_d     = mem[rd_ptr_q[AW-1:0]];
      m_valid_d = 1'b1;
    end else if (bypass) begin
      out_d     = s_beat;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      out_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      m_valid_q <= m_valid_d;
      out_q     <= out_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (write_arr) begin
      mem[wr_ptr_q[AW-1:0]] <= s_beat;
    end
  end

endmodule
